// File: rtl/cmos_8_16bit_capture.sv
// DVP capture front end: pairs camera bytes into RGB565 words, skips start-up
// frames, tracks pixel coordinates and flags lines/frames of the wrong size.
module cmos_8_16bit_capture #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned V_ACTIVE    = 272,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter bit          HI_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_db,
    output logic [15:0] cmos_16bit_data,
    output logic        cmos_16bit_wr,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_end,
    output logic        err_line,
    output logic [7:0]  frame_cnt
);
    localparam int unsigned SKW = $clog2(SKIP_FRAMES + 2);
    localparam int unsigned XW  = 11;
    localparam int unsigned YW  = 10;

    typedef enum logic [1:0] {SKIP, WAIT_VS, ACTIVE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_vs1, r_vs2, r_href1, r_href2;
    logic [7:0]     r_db1;
    logic [7:0]     r_byte;
    logic           r_phase;
    logic [SKW-1:0] r_skip;
    logic [XW-1:0]  r_xcnt;
    logic [YW-1:0]  r_ycnt;

    logic           w_vs_rise, w_vs_fall, w_href_fall;
    logic           w_start, w_done, w_lend, w_byte, w_skip_inc;
    logic [YW-1:0]  w_ycnt_inc, w_ycnt_end;

    assign w_vs_rise   = r_vs1 & ~r_vs2;
    assign w_vs_fall   = ~r_vs1 & r_vs2;
    assign w_href_fall = ~r_href1 & r_href2;
    assign w_ycnt_inc  = (r_ycnt == '1) ? r_ycnt : r_ycnt + YW'(1);
    // Line count as it stands after this cycle, so a line ending together with vsync is included
    assign w_ycnt_end  = w_lend ? w_ycnt_inc : r_ycnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= SKIP;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_lend       = 1'b0;
        w_byte       = 1'b0;
        w_skip_inc   = 1'b0;
        case (r_state)
            SKIP: begin
                if (r_skip == SKW'(SKIP_FRAMES)) w_state_next = WAIT_VS;
                else if (w_vs_rise)              w_skip_inc   = 1'b1;
            end
            WAIT_VS: begin
                if (w_vs_fall) begin
                    w_start      = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                w_lend = w_href_fall;
                w_byte = r_href1;
                if (w_vs_rise) begin
                    w_done       = 1'b1;
                    w_state_next = WAIT_VS;
                end
            end
            default: w_state_next = SKIP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs1           <= 1'b0;
            r_vs2           <= 1'b0;
            r_href1         <= 1'b0;
            r_href2         <= 1'b0;
            r_db1           <= 8'd0;
            r_byte          <= 8'd0;
            r_phase         <= 1'b0;
            r_skip          <= '0;
            r_xcnt          <= '0;
            r_ycnt          <= '0;
            cmos_16bit_data <= 16'd0;
            cmos_16bit_wr   <= 1'b0;
            pixel_x         <= 10'd0;
            pixel_y         <= 10'd0;
            frame_start     <= 1'b0;
            frame_done      <= 1'b0;
            line_end        <= 1'b0;
            err_line        <= 1'b0;
            frame_cnt       <= 8'd0;
        end else begin
            r_vs1         <= cmos_vsync;
            r_vs2         <= r_vs1;
            r_href1       <= cmos_href;
            r_href2       <= r_href1;
            r_db1         <= cmos_db;
            cmos_16bit_wr <= 1'b0;
            frame_start   <= w_start;
            frame_done    <= w_done;
            line_end      <= w_lend;

            if (w_skip_inc) r_skip <= r_skip + SKW'(1);

            if (w_start) begin
                err_line  <= 1'b0;
                pixel_x   <= 10'd0;
                pixel_y   <= 10'd0;
                frame_cnt <= frame_cnt + 8'd1;
                r_xcnt    <= '0;
                r_ycnt    <= '0;
                r_phase   <= 1'b0;
            end

            // Byte pairing: phase 0 holds the first byte, phase 1 emits the word
            if (w_byte) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_byte <= r_db1;
                end else begin
                    cmos_16bit_data <= HI_FIRST ? {r_byte, r_db1} : {r_db1, r_byte};
                    cmos_16bit_wr   <= (r_xcnt < XW'(H_ACTIVE)) && (r_ycnt < YW'(V_ACTIVE));
                    pixel_x         <= 10'(r_xcnt);
                    pixel_y         <= r_ycnt;
                    if (r_xcnt != '1) r_xcnt <= r_xcnt + XW'(1);
                end
            end

            if (w_lend) begin
                r_phase <= 1'b0;
                r_xcnt  <= '0;
                r_ycnt  <= w_ycnt_inc;
                pixel_x <= 10'd0;
                pixel_y <= w_ycnt_inc;
                if (r_phase || (r_xcnt != XW'(H_ACTIVE))) err_line <= 1'b1;
            end

            if (w_done && (w_ycnt_end != YW'(V_ACTIVE))) err_line <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmos_8_16bit_capture.sv
// Bench for cmos_8_16bit_capture: two instances (skip 2 / high byte first,
// skip 0 / low byte first) driven by one DVP stream and checked against a frame model.
module tb_cmos_8_16bit_capture;
    localparam int H = 8;
    localparam int V = 4;

    typedef struct packed {
        logic [27:0] cyc;
        logic [15:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs, href;
    logic [7:0]  db;
    logic [15:0] o_data [2];
    logic        o_wr   [2];
    logic [9:0]  o_x    [2];
    logic [9:0]  o_y    [2];
    logic        o_fs   [2];
    logic        o_fd   [2];
    logic        o_le   [2];
    logic        o_err  [2];
    logic [7:0]  o_fcnt [2];

    cmos_8_16bit_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2), .HI_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .cmos_vsync(vs), .cmos_href(href), .cmos_db(db),
        .cmos_16bit_data(o_data[0]), .cmos_16bit_wr(o_wr[0]), .pixel_x(o_x[0]), .pixel_y(o_y[0]),
        .frame_start(o_fs[0]), .frame_done(o_fd[0]), .line_end(o_le[0]), .err_line(o_err[0]),
        .frame_cnt(o_fcnt[0]));

    cmos_8_16bit_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0), .HI_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .cmos_vsync(vs), .cmos_href(href), .cmos_db(db),
        .cmos_16bit_data(o_data[1]), .cmos_16bit_wr(o_wr[1]), .pixel_x(o_x[1]), .pixel_y(o_y[1]),
        .frame_start(o_fs[1]), .frame_done(o_fd[1]), .line_end(o_le[1]), .err_line(o_err[1]),
        .frame_cnt(o_fcnt[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes and pulse totals
    ev_t act_q [2][$];
    int  fs_m [2], fd_m [2], le_m [2], both_m [2];
    initial for (int k = 0; k < 2; k++) begin fs_m[k] = 0; fd_m[k] = 0; le_m[k] = 0; both_m[k] = 0; end
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_wr[k]) act_q[k].push_back({28'(cyc), o_data[k], o_x[k], o_y[k]});
            fs_m[k]   = fs_m[k] + int'(o_fs[k]);
            fd_m[k]   = fd_m[k] + int'(o_fd[k]);
            le_m[k]   = le_m[k] + int'(o_le[k]);
            both_m[k] = both_m[k] + int'(o_le[k] & o_fd[k]);
        end
    end

    // Reference model state
    int  skip_cfg [2];
    bit  hi_cfg   [2];
    int  rises [2], lidx [2], fcnt_e [2];
    bit  act [2], err_e [2];
    int  fs_e [2], fd_e [2], le_e [2], both_e [2], done [2];
    ev_t exp_q [2][$];
    bit  pend;
    int  pat;
    int  checks, errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s_%s", s, (k == 0) ? "a" : "b");
    endfunction

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk);
        #1;
        vs = v; href = h; db = d;
    endtask

    function automatic logic [7:0] gen_byte(input int j);
        case (pat)
            1:       return (j % 2 == 0) ? 8'h12 : 8'hAB - 8'h77;
            2:       return (j % 2 == 0) ? 8'hAB : 8'hCD;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            rises[k] = 0; lidx[k] = 0; fcnt_e[k] = 0; act[k] = 1'b0; err_e[k] = 1'b0;
        end
    endtask

    task automatic model_rise();
        for (int k = 0; k < 2; k++) begin
            rises[k]++;
            if (act[k]) begin
                if (lidx[k] != V) err_e[k] = 1'b1;
                fd_e[k]++;
                act[k] = 1'b0;
            end
        end
    endtask

    task automatic model_fall();
        for (int k = 0; k < 2; k++) begin
            if (!act[k] && rises[k] >= skip_cfg[k]) begin
                act[k] = 1'b1; err_e[k] = 1'b0; lidx[k] = 0;
                fcnt_e[k] = (fcnt_e[k] + 1) % 256;
                fs_e[k]++;
            end
        end
    endtask

    // Expected words of a line: pair i is strobed 2 cycles after its second byte
    task automatic model_words(input logic [7:0] b [$], input int t0, input int npairs);
        ev_t e;
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                for (int i = 0; i < npairs; i++) begin
                    if (i < H && lidx[k] < V) begin
                        e.cyc = 28'(t0 + 2 * i + 3);
                        e.d   = hi_cfg[k] ? {b[2*i], b[2*i+1]} : {b[2*i+1], b[2*i]};
                        e.x   = 10'(i);
                        e.y   = 10'(lidx[k]);
                        exp_q[k].push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic do_line(input int nbytes, input bit hold);
        logic [7:0] b [$];
        int t0;
        t0 = 0;
        for (int j = 0; j < nbytes; j++) begin
            drive(1'b0, 1'b1, gen_byte(j));
            if (j == 0) t0 = cyc;
            b.push_back(db);
        end
        model_words(b, t0, nbytes / 2);
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                if ((nbytes % 2) != 0 || (nbytes / 2) != H) err_e[k] = 1'b1;
                le_e[k]++;
                if (lidx[k] < 1023) lidx[k]++;
            end
        end
        pend = hold;
        if (!hold) repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++)
            chk(tg("rst_outputs", k), 64'({o_data[k], o_wr[k], o_x[k], o_y[k], o_fs[k],
                                         o_fd[k], o_le[k], o_err[k], o_fcnt[k]}), 64'd0);
    endtask

    // rst pulsed together with byte jr of a line inside the current frame
    task automatic do_line_rst(input int nbytes, input int jr);
        logic [7:0] b [$];
        int t0;
        t0 = 0;
        for (int j = 0; j < nbytes; j++) begin
            drive(1'b0, 1'b1, gen_byte(j));
            rst = (j == jr);
            if (j == 0) t0 = cyc;
            b.push_back(db);
            if (j == jr + 1) begin
                @(negedge clk);
                #1;
                check_reset_outputs();
            end
        end
        model_words(b, t0, (jr - 1) / 2);
        reset_model();
        repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_frame();
        for (int k = 0; k < 2; k++) begin
            chk(tg("nwords", k), 64'(act_q[k].size()), 64'(exp_q[k].size()));
            for (int i = done[k]; i < exp_q[k].size() && i < act_q[k].size(); i++)
                chk($sformatf("word%0d_%s", i, (k == 0) ? "a" : "b"), 64'(act_q[k][i]), 64'(exp_q[k][i]));
            done[k] = exp_q[k].size();
            chk(tg("frame_start_cnt", k), 64'(fs_m[k]), 64'(fs_e[k]));
            chk(tg("frame_done_cnt", k), 64'(fd_m[k]), 64'(fd_e[k]));
            chk(tg("line_end_cnt", k), 64'(le_m[k]), 64'(le_e[k]));
            chk(tg("le_fd_same_cycle", k), 64'(both_m[k]), 64'(both_e[k]));
            chk(tg("err_at_done", k), 64'(o_err[k]), 64'(err_e[k]));
        end
    endtask

    // vsync blanking closes the previous frame, then a vsync fall opens the next
    task automatic open_frame();
        drive(1'b1, 1'b0, 8'h00);
        if (pend) for (int k = 0; k < 2; k++) both_e[k] += int'(act[k]);
        pend = 1'b0;
        model_rise();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        check_frame();
        drive(1'b0, 1'b0, 8'h00);
        model_fall();
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(tg("err_at_start", k), 64'(o_err[k]), 64'(err_e[k]));
            chk(tg("frame_cnt", k), 64'(o_fcnt[k]), 64'(fcnt_e[k]));
        end
    endtask

    task automatic full_frame(input int nlines);
        open_frame();
        for (int l = 0; l < nlines; l++) do_line(2 * H, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0; pend = 1'b0; pat = 1;
        skip_cfg[0] = 2; skip_cfg[1] = 0;
        hi_cfg[0] = 1'b1; hi_cfg[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fs_e[k] = 0; fd_e[k] = 0; le_e[k] = 0; both_e[k] = 0; done[k] = 0;
        end
        reset_model();
        rst = 1'b1; vs = 1'b0; href = 1'b0; db = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        drive(1'b0, 1'b0, 8'h00);
        rst = 1'b0;

        // Start-up frames with fixed 0x12,0x34 bytes, then one with 0xAB,0xCD
        repeat (3) full_frame(V);
        pat = 2;
        full_frame(V);
        pat = 0;

        // Odd byte count on one line; following line must re-pair cleanly
        open_frame();
        do_line(2 * H, 1'b0);
        do_line(2 * H + 1, 1'b0);
        do_line(2 * H, 1'b0);
        do_line(2 * H, 1'b0);

        // Over-long line, then too many lines, then too few
        open_frame();
        do_line(2 * H + 4, 1'b0);
        for (int l = 1; l < V; l++) do_line(2 * H, 1'b0);
        full_frame(V + 2);
        full_frame(V - 1);

        // Last line ends in the same cycle vsync rises
        open_frame();
        for (int l = 0; l < V - 1; l++) do_line(2 * H, 1'b0);
        do_line(2 * H, 1'b1);

        // Randomized geometry
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = int'($urandom_range(V + 1, V - 1));
            open_frame();
            for (int l = 0; l < nl; l++) begin
                int nb;
                nb = 2 * H;
                if ($urandom_range(3, 0) == 0) nb = int'($urandom_range(2 * H + 3, 2 * H - 3));
                do_line(nb, 1'b0);
            end
        end

        // Reset in the middle of an accepted line
        open_frame();
        do_line(2 * H, 1'b0);
        do_line_rst(2 * H, 7);

        // Enough tiny frames for the skip-0 instance to wrap frame_cnt
        for (int f = 0; f < 257; f++) begin
            open_frame();
            do_line(2, 1'b0);
        end

        open_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmos_8_16bit_capture.md
Name: cmos_8_16bit_capture

Overview:
- DVP capture front end for the OV5640 pmod path.
- Samples the camera's 8-bit byte stream (cmos_db) and pairs bytes into RGB565 words (cmos_16bit_data), with a write strobe and pixel/line coordinates.
- Output feeds the frame-buffer write path (write_data) and is exposed to the debug probe set.
- Discards start-up frames and flags malformed lines.

Parameters:
- H_ACTIVE, 480: expected pixels (16-bit words) per line.
- V_ACTIVE, 272: expected lines per frame.
- SKIP_FRAMES, 10: whole frames discarded after reset, counted as vsync rising edges; 0 means no skip.
- HI_FIRST, 1: 1 = first byte of a pair is bits [15:8]; 0 = first byte is bits [7:0].

Ports:
- clk  in  1  camera pixel clock (pclk); the only clock.
- rst  in  1  synchronous, active-high reset.
- cmos_vsync  in  1  frame sync, active high (high = blanking).
- cmos_href  in  1  line valid, active high.
- cmos_db  in  8  camera data byte.
- cmos_16bit_data  out  16  assembled pixel word.
- cmos_16bit_wr  out  1  one-cycle strobe: cmos_16bit_data valid.
- pixel_x  out  10  column of the current word, 0..H_ACTIVE-1.
- pixel_y  out  10  line of the current word, 0..V_ACTIVE-1.
- frame_start  out  1  one-cycle pulse when an accepted frame begins.
- frame_done  out  1  one-cycle pulse when an accepted frame ends.
- line_end  out  1  one-cycle pulse on the href falling edge inside an accepted frame.
- err_line  out  1  sticky error flag, cleared at frame_start.
- frame_cnt  out  8  accepted frames, wraps at 255 to 0.

Behaviour:
- Input stage: cmos_vsync, cmos_href and cmos_db are registered once (stage 1). All edge detection uses stage 1 against its previous value (stage 2).
- Reset (synchronous, any time, including mid-line):
  - all outputs 0; state = SKIP; skip counter = 0; byte phase = 0.
  - first output word is produced only after a fresh vsync fall that follows the skip period.
- State machine:
  - SKIP: each vsync rising edge increments the skip counter. When the counter reaches SKIP_FRAMES, go to WAIT_VS. With SKIP_FRAMES = 0, go to WAIT_VS immediately after reset.
  - WAIT_VS: on a vsync falling edge, go to ACTIVE. In that cycle: pulse frame_start, clear err_line, clear pixel_y, increment frame_cnt.
  - ACTIVE:
    - vsync rising edge: pulse frame_done; go to WAIT_VS.
    - If the vsync rising edge coincides with an href falling edge, line_end and frame_done pulse in the same cycle.
- Byte pairing (ACTIVE, href = 1 in stage 1):
  - byte phase toggles every cycle.
  - phase 0: latch the byte.
  - phase 1: form the word according to HI_FIRST.
  - cmos_16bit_wr = 1 in the following cycle, with cmos_16bit_data, pixel_x and pixel_y aligned to it.
  - Latency: 2 clk from the second byte at the pins to the wr strobe.
- Counters and limits:
  - pixel_x increments after each word.
  - Words with pixel_x >= H_ACTIVE, or lines with pixel_y >= V_ACTIVE, are counted but not strobed (wr stays 0).
- href falling edge (ACTIVE):
  - pulse line_end; pixel_x = 0; pixel_y += 1, saturating at 1023; byte phase = 0.
  - err_line is set if byte phase was 1 (odd byte count; the partial byte is dropped) or the word count ≠ H_ACTIVE.
- End of frame: at frame_done, err_line is set if the line count ≠ V_ACTIVE.
- href outside ACTIVE is ignored; no wr, line_end or counter change.
- frame_cnt wraps 255 to 0 without a flag.

Test Plan:
- SKIP_FRAMES = 2: drive 3 frames of 480x272 with bytes 0x12,0x34 repeated.
  - No wr during frames 1–2.
  - Frame 3: frame_start once, 130560 wr strobes, all data 0x1234, last strobe at x = 479, y = 271, frame_done once, err_line = 0, frame_cnt = 1.
- HI_FIRST = 0 with bytes 0xAB,0xCD -> data 0xCDAB; wr exactly 2 clk after the second byte at the pins.
- One line of 961 bytes -> err_line = 1 after that line's line_end; 480 strobes on the line; next line starts at x = 0 with correct pairing; err_line cleared at the next frame_start.
- Line of 500 words -> only 480 strobes, err_line = 1. Frame of 280 lines -> strobes stop after y = 271, err_line = 1 at frame_done.
- rst asserted mid-line in the accepted frame -> next cycle all outputs 0; no wr until SKIP_FRAMES vsync rises plus a vsync fall.
- 256 accepted frames with SKIP_FRAMES = 0 -> frame_cnt reads 0 after the 256th frame_start.
